bsg_manycore_ram_latency_gate: RTL and testbench



---
 rtl/bsg_manycore_ram_latency_gate_if.sv | 43 ++++
 rtl/bsg_manycore_ram_latency_gate.sv | 127 ++++++++++++
 tb/tb_bsg_manycore_ram_latency_gate.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bsg_manycore_ram_latency_gate_if.sv
// rtl/bsg_manycore_ram_latency_gate_if.sv - endpoint request/response and RAM port bundle for the latency gate
interface bsg_manycore_ram_latency_gate_if #(
  parameter int data_width_p  = 32,
  parameter int addr_width_p  = 26,
  parameter int els_p         = 1024,
  parameter int count_width_p = 32
);
  localparam int mem_addr_width_lp = $clog2(els_p);
  localparam int mask_width_lp     = data_width_p >> 3;

  logic                         in_v_i;
  logic                         in_we_i;
  logic [addr_width_p-1:0]      in_addr_i;
  logic [data_width_p-1:0]      in_data_i;
  logic [mask_width_lp-1:0]     in_mask_i;
  logic                         in_yumi_o;

  logic                         mem_v_o;
  logic                         mem_w_o;
  logic [mem_addr_width_lp-1:0] mem_addr_o;
  logic [data_width_p-1:0]      mem_data_o;
  logic [mask_width_lp-1:0]     mem_mask_o;
  logic [data_width_p-1:0]      mem_data_i;

  logic                         returning_v_o;
  logic [data_width_p-1:0]      returning_data_o;

  logic                         oob_o;
  logic [count_width_p-1:0]     read_count_o;
  logic [count_width_p-1:0]     write_count_o;

  modport slave (
    input  in_v_i, in_we_i, in_addr_i, in_data_i, in_mask_i, mem_data_i,
    output in_yumi_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_mask_o,
    output returning_v_o, returning_data_o, oob_o, read_count_o, write_count_o
  );

  modport master (
    output in_v_i, in_we_i, in_addr_i, in_data_i, in_mask_i, mem_data_i,
    input  in_yumi_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_mask_o,
    input  returning_v_o, returning_data_o, oob_o, read_count_o, write_count_o
  );
endinterface

// File: rtl/bsg_manycore_ram_latency_gate.sv
// rtl/bsg_manycore_ram_latency_gate.sv - holds endpoint requests for latency_p cycles before issuing them to a 1rw RAM
module bsg_manycore_ram_latency_gate #(
  parameter int data_width_p  = 32,
  parameter int addr_width_p  = 26,
  parameter int els_p         = 1024,
  parameter int latency_p     = 8,
  parameter int count_width_p = 32
) (
  input logic clk_i,
  input logic reset_i,
  bsg_manycore_ram_latency_gate_if.slave bus
);
  localparam int mem_addr_width_lp = $clog2(els_p);
  localparam int mask_width_lp     = data_width_p >> 3;
  localparam int cnt_width_lp      = (latency_p < 1) ? 1 : $clog2(latency_p + 1);
  localparam logic [addr_width_p:0] els_lp = (addr_width_p + 1)'(els_p);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e                  state_r, state_n;
  logic [cnt_width_lp-1:0] cnt_r, cnt_n;
  logic                    issue_raw;
  logic                    issue;
  logic                    oob;

  logic                     returning_v_r;
  logic                     oob_read_r;
  logic                     oob_r;
  logic [count_width_p-1:0] read_count_r;
  logic [count_width_p-1:0] write_count_r;

  // The request is never latched; the endpoint FIFO keeps it stable until yumi.
  assign oob = ({1'b0, bus.in_addr_i} >= els_lp);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    issue_raw = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.in_v_i) begin
          if (latency_p == 0) begin
            issue_raw = 1'b1;
          end else begin
            cnt_n   = cnt_width_lp'(latency_p - 1);
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_r != '0) begin
          cnt_n = cnt_r - cnt_width_lp'(1);
        end else begin
          issue_raw = 1'b1;
          state_n   = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Reset is asynchronous, so the combinational issue path must be blocked directly.
  assign issue = issue_raw & ~reset_i;

  always_comb begin
    bus.in_yumi_o  = issue;
    bus.mem_v_o    = issue & ~oob;
    bus.mem_w_o    = issue & ~oob & bus.in_we_i;
    bus.mem_addr_o = {mem_addr_width_lp{1'b0}};
    bus.mem_data_o = {data_width_p{1'b0}};
    bus.mem_mask_o = {mask_width_lp{1'b0}};
    if (issue) begin
      bus.mem_addr_o = bus.in_addr_i[mem_addr_width_lp-1:0];
      bus.mem_data_o = bus.in_data_i;
      bus.mem_mask_o = bus.in_mask_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      returning_v_r <= 1'b0;
      oob_read_r    <= 1'b0;
      oob_r         <= 1'b0;
      read_count_r  <= '0;
      write_count_r <= '0;
    end else begin
      returning_v_r <= issue;
      oob_read_r    <= issue & oob & ~bus.in_we_i;
      if (issue & oob) begin
        oob_r <= 1'b1;
      end
      if (issue & ~bus.in_we_i) begin
        read_count_r <= read_count_r + count_width_p'(1);
      end
      if (issue & bus.in_we_i) begin
        write_count_r <= write_count_r + count_width_p'(1);
      end
    end
  end

  // An out-of-range read never touched the RAM, so its stale output is masked off.
  assign bus.returning_v_o    = returning_v_r;
  assign bus.returning_data_o = oob_read_r ? {data_width_p{1'b0}} : bus.mem_data_i;
  assign bus.oob_o            = oob_r;
  assign bus.read_count_o     = read_count_r;
  assign bus.write_count_o    = write_count_r;

  a_req_stable_in_wait: assert property (
    @(posedge clk_i) disable iff (reset_i)
    (state_r == S_WAIT) |-> $stable({bus.in_v_i, bus.in_we_i, bus.in_addr_i, bus.in_data_i, bus.in_mask_i})
  );
endmodule

// File: tb/tb_bsg_manycore_ram_latency_gate.sv
// tb/tb_bsg_manycore_ram_latency_gate.sv - scoreboard bench over three gate configurations
module tb_bsg_manycore_ram_latency_gate;
  localparam int N = 3;
  localparam int LAT [N] = '{8, 0, 3};
  localparam int CW  [N] = '{32, 4, 32};

  typedef struct {
    int          inst;
    int          due;
    bit          chk;
    logic [31:0] data;
  } resp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int errors  = 0;
  resp_t exp_q [$];

  logic [N-1:0] rst, in_v, in_we;
  logic [25:0]  in_addr [N];
  logic [31:0]  in_data [N];
  logic [3:0]   in_mask [N];
  logic [N-1:0] yumi, memv, memw, rv, oob;
  logic [9:0]   maddr [N];
  logic [31:0]  mdata [N];
  logic [3:0]   mmask [N];
  logic [31:0]  ram_q [N];
  logic [31:0]  rdata [N];
  logic [31:0]  rcnt [N];
  logic [31:0]  wcnt [N];
  logic [31:0]  mem [N][1024];

  for (genvar g = 0; g < N; g++) begin : g_dut
    bsg_manycore_ram_latency_gate_if #(.count_width_p(CW[g])) bus ();
    assign bus.in_v_i     = in_v[g];
    assign bus.in_we_i    = in_we[g];
    assign bus.in_addr_i  = in_addr[g];
    assign bus.in_data_i  = in_data[g];
    assign bus.in_mask_i  = in_mask[g];
    assign bus.mem_data_i = ram_q[g];
    assign yumi[g]  = bus.in_yumi_o;
    assign memv[g]  = bus.mem_v_o;
    assign memw[g]  = bus.mem_w_o;
    assign maddr[g] = bus.mem_addr_o;
    assign mdata[g] = bus.mem_data_o;
    assign mmask[g] = bus.mem_mask_o;
    assign rv[g]    = bus.returning_v_o;
    assign rdata[g] = bus.returning_data_o;
    assign oob[g]   = bus.oob_o;
    assign rcnt[g]  = 32'(bus.read_count_o);
    assign wcnt[g]  = 32'(bus.write_count_o);

    bsg_manycore_ram_latency_gate #(
      .latency_p    (LAT[g]),
      .count_width_p(CW[g])
    ) dut (
      .clk_i  (clk),
      .reset_i(rst[g]),
      .bus    (bus.slave)
    );
  end

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Behavioral 1rw RAM: read data appears the cycle after the access.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (memv[i]) begin
        if (memw[i]) mem[i][maddr[i]] <= merge(mem[i][maddr[i]], mdata[i], mmask[i]);
        else         ram_q[i] <= mem[i][maddr[i]];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    int idx;
    for (int i = 0; i < N; i++) begin
      if (rv[i]) begin
        idx = -1;
        for (int k = 0; k < exp_q.size(); k++) begin
          if (exp_q[k].inst == i) begin
            idx = k;
            break;
          end
        end
        if (idx < 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_resp: inst %0d got returning_v at cycle %0d, expected none", i, cyc);
        end else begin
          check("resp_cycle", 32'(cyc), 32'(exp_q[idx].due));
          if (exp_q[idx].chk) check("resp_data", rdata[i], exp_q[idx].data);
          exp_q.delete(idx);
        end
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge that follows the issue, with in_v dropped.
  task automatic req(input int i, input logic w, input logic [25:0] a, input logic [31:0] d,
                     input logic [3:0] m, input bit push, input bit chk, input logic [31:0] ed,
                     output int issue_cyc);
    int    t0;
    bit    seen;
    bit    in_range;
    resp_t r;
    in_v[i] = 1'b1; in_we[i] = w; in_addr[i] = a; in_data[i] = d; in_mask[i] = m;
    t0 = cyc; seen = 1'b0; issue_cyc = -1;
    in_range = (a < 26'd1024);
    for (int k = 0; k <= LAT[i] + 4; k++) begin
      @(negedge clk);
      if (yumi[i]) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!seen) begin
      vectors++;
      errors++;
      $display("FAIL yumi_timeout: inst %0d addr 0x%0h got no yumi, expected one after %0d cycles", i, a, LAT[i]);
    end else begin
      issue_cyc = cyc;
      check("yumi_latency", 32'(cyc - t0), 32'(LAT[i]));
      check("mem_v", 32'(memv[i]), 32'(in_range));
      check("mem_w", 32'(memw[i]), 32'(in_range & w));
      if (in_range) check("mem_addr", 32'(maddr[i]), 32'(a[9:0]));
      if (in_range && w) begin
        check("mem_data", mdata[i], d);
        check("mem_mask", 32'(mmask[i]), 32'(m));
      end
      if (push) begin
        r.inst = i; r.due = cyc + 1; r.chk = chk; r.data = ed;
        exp_q.push_back(r);
      end
    end
    @(posedge clk); #1;
    in_v[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int    ic;
    int    first;
    int    t0;
    resp_t r;
    rst = '1; in_v = '0; in_we = '0;
    for (int i = 0; i < N; i++) begin
      in_addr[i] = '0; in_data[i] = '0; in_mask[i] = '0;
    end
    in_v[1] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check("reset_yumi", 32'(yumi[i]), 32'd0);
      check("reset_mem_v", 32'(memv[i]), 32'd0);
      check("reset_ret_v", 32'(rv[i]), 32'd0);
      check("reset_oob", 32'(oob[i]), 32'd0);
      check("reset_rcnt", rcnt[i], 32'd0);
      check("reset_wcnt", wcnt[i], 32'd0);
    end
    @(posedge clk); #1;
    in_v[1] = 1'b0;
    rst = '0;
    @(posedge clk); #1;

    // latency 8: write then read back
    req(0, 1'b1, 26'd5, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 32'h0, ic);
    check("t1_write_count", wcnt[0], 32'd1);
    req(0, 1'b0, 26'd5, 32'h0, 4'h0, 1'b1, 1'b1, 32'hDEADBEEF, ic);
    check("t1_read_count", rcnt[0], 32'd1);

    // partial byte mask over a full write
    req(0, 1'b1, 26'd7, 32'hAAAAAAAA, 4'hF, 1'b1, 1'b0, 32'h0, ic);
    req(0, 1'b1, 26'd7, 32'h11223344, 4'h3, 1'b1, 1'b0, 32'h0, ic);
    req(0, 1'b0, 26'd7, 32'h0, 4'h0, 1'b1, 1'b1, 32'hAAAA3344, ic);

    // out-of-range read, then a good read
    check("t4_oob_before", 32'(oob[0]), 32'd0);
    req(0, 1'b0, 26'd1024, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0, ic);
    check("t4_oob_set", 32'(oob[0]), 32'd1);
    repeat (3) @(posedge clk); #1;
    check("t4_oob_sticky", 32'(oob[0]), 32'd1);
    req(0, 1'b0, 26'd5, 32'h0, 4'h0, 1'b1, 1'b1, 32'hDEADBEEF, ic);
    check("t4_oob_still", 32'(oob[0]), 32'd1);
    check("t4_read_count", rcnt[0], 32'd4);
    check("t4_write_count", wcnt[0], 32'd3);

    // latency 0, 4-bit counters: 17 back-to-back writes wrap the write count
    for (int k = 0; k < 17; k++) begin
      req(1, 1'b1, 26'(k), 32'h1000 + 32'(k), 4'hF, 1'b1, 1'b0, 32'h0, ic);
      if (k == 0) first = ic;
      else check("t5_back_to_back", 32'(ic - first), 32'(k));
      if (k == 15) check("t5_wrap_zero", wcnt[1], 32'd0);
    end
    check("t5_write_count", wcnt[1], 32'd1);
    check("t5_read_count", rcnt[1], 32'd0);

    // latency 0: four back-to-back reads, responses in order on consecutive cycles
    for (int k = 0; k < 4; k++) begin
      req(1, 1'b0, 26'(k), 32'h0, 4'h0, 1'b1, 1'b1, 32'h1000 + 32'(k), ic);
      if (k == 0) first = ic;
      else check("t2_back_to_back", 32'(ic - first), 32'(k));
    end
    check("t2_read_count", rcnt[1], 32'd4);

    // latency 3: reset pulsed mid-wait restarts the full wait
    req(2, 1'b1, 26'd9, 32'h5A5A5A5A, 4'hF, 1'b1, 1'b0, 32'h0, ic);
    check("t3_pre_wcnt", wcnt[2], 32'd1);
    in_v[2] = 1'b1; in_we[2] = 1'b0; in_addr[2] = 26'd9; in_data[2] = '0; in_mask[2] = '0;
    t0 = cyc;
    for (int k = 0; k < 7; k++) begin
      if (k == 2) rst[2] = 1'b1;
      if (k == 3) rst[2] = 1'b0;
      @(negedge clk);
      if (k == 2) begin
        check("t3_wcnt_in_reset", wcnt[2], 32'd0);
        check("t3_rcnt_in_reset", rcnt[2], 32'd0);
      end
      if (k < 6) begin
        check("t3_no_early_yumi", 32'(yumi[2]), 32'd0);
      end else begin
        check("t3_yumi_cycle", 32'(cyc - t0), 32'd6);
        check("t3_yumi", 32'(yumi[2]), 32'd1);
        check("t3_mem_v", 32'(memv[2]), 32'd1);
        r.inst = 2; r.due = cyc + 1; r.chk = 1'b1; r.data = 32'h5A5A5A5A;
        exp_q.push_back(r);
      end
      @(posedge clk); #1;
    end
    in_v[2] = 1'b0;

    // reset in the cycle after issue drops the pending response
    req(2, 1'b1, 26'd10, 32'h77, 4'hF, 1'b0, 1'b0, 32'h0, ic);
    rst[2] = 1'b1;
    @(negedge clk);
    check("t3_ret_v_cleared", 32'(rv[2]), 32'd0);
    check("t3_wcnt_cleared", wcnt[2], 32'd0);
    @(posedge clk); #1;
    rst[2] = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
